// File: rtl/dft_pkg.sv
// Shared types for the DFT frame sequencer: FSM state encoding and the
// block-exponent width used by the transform core.
package dft_pkg;

  typedef enum logic [1:0] {
    FILL,
    WAIT_RFFD,
    FEED,
    DRAIN
  } state_t;

  localparam int EXP_W = 4;

endpackage

// File: rtl/dft_frame_sequencer_if.sv
// Bundle of the sample input stream, the transform-core handshake and the bin
// result stream. The master modport is the sequencer side.
interface dft_frame_sequencer_if import dft_pkg::*; #(
  parameter int N      = 18,
  parameter int POINTS = 64
) ();

  localparam int AW = $clog2(POINTS);

  logic [N-1:0]     sample_in;
  logic             sample_valid;
  logic             sample_ready;

  logic [N-1:0]     XN_RE;
  logic             FD_IN;
  logic             RFFD;
  logic [N-1:0]     XK_RE;
  logic [N-1:0]     XK_IM;
  logic [EXP_W-1:0] BLK_EXP;
  logic             DATA_VALID;

  logic [N-1:0]     bin_re;
  logic [N-1:0]     bin_im;
  logic [EXP_W-1:0] bin_exp;
  logic [AW-1:0]    bin_idx;
  logic             bin_valid;
  logic             frame_done;
  logic             err;

  modport master (
    input  sample_in, sample_valid, RFFD, XK_RE, XK_IM, BLK_EXP, DATA_VALID,
    output sample_ready, XN_RE, FD_IN,
           bin_re, bin_im, bin_exp, bin_idx, bin_valid, frame_done, err
  );

  modport slave (
    output sample_in, sample_valid, RFFD, XK_RE, XK_IM, BLK_EXP, DATA_VALID,
    input  sample_ready, XN_RE, FD_IN,
           bin_re, bin_im, bin_exp, bin_idx, bin_valid, frame_done, err
  );

endinterface

// File: rtl/dft_frame_buf.sv
// Single-write, single-read frame buffer with a combinational read port, so the
// addressed point appears on rd_data in the same cycle the address is presented.
module dft_frame_buf #(
  parameter int N      = 18,
  parameter int POINTS = 64,
  localparam int AW    = $clog2(POINTS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem [POINTS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dft_frame_sequencer.sv
// Collects a frame of samples, streams it into a transform core and registers
// the returned bins. Define DFT_SEQ_TIMEOUT_EN to bound the DRAIN phase.
module dft_frame_sequencer import dft_pkg::*; #(
  parameter int N       = 18,
  parameter int POINTS  = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic                  CLK_125MHZ_FPGA,
  input  logic                  SCLR,
  dft_frame_sequencer_if.master bus
);

  localparam int            AW   = $clog2(POINTS);
  localparam logic [AW-1:0] LAST = AW'(POINTS - 1);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] cnt;
  logic          wr_en;
  logic          last_bin;
  logic          timeout_hit;
  logic [N-1:0]  rd_data;

  // One counter serves as write pointer, feed pointer and bin index; it is
  // cleared on every state change so each phase starts from point 0.
  dft_frame_buf #(.N(N), .POINTS(POINTS)) u_buf (
    .clk     (CLK_125MHZ_FPGA),
    .we      (wr_en),
    .wr_addr (cnt),
    .wr_data (bus.sample_in),
    .rd_addr (cnt),
    .rd_data (rd_data)
  );

  assign last_bin = (state == DRAIN) && bus.DATA_VALID && (cnt == LAST);

`ifdef DFT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] drain_cycles;

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (SCLR || state != DRAIN) drain_cycles <= '0;
    else                        drain_cycles <= drain_cycles + 1'b1;
  end

  assign timeout_hit = (state == DRAIN) && (drain_cycles == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (SCLR) state <= FILL;
    else      state <= next_state;
  end

  always_comb begin
    next_state       = state;
    wr_en            = 1'b0;
    bus.sample_ready = 1'b0;
    bus.XN_RE        = '0;
    bus.FD_IN        = 1'b0;
    case (state)
      FILL: begin
        bus.sample_ready = 1'b1;
        wr_en            = bus.sample_valid;
        if (bus.sample_valid && cnt == LAST) next_state = WAIT_RFFD;
      end
      WAIT_RFFD: begin
        if (bus.RFFD) next_state = FEED;
      end
      FEED: begin
        bus.XN_RE = rd_data;
        bus.FD_IN = (cnt == '0);
        if (cnt == LAST) next_state = DRAIN;
      end
      DRAIN: begin
        if (last_bin || timeout_hit) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (SCLR || next_state != state) begin
      cnt <= '0;
    end else begin
      case (state)
        FILL:    if (bus.sample_valid) cnt <= cnt + 1'b1;
        FEED:    cnt <= cnt + 1'b1;
        DRAIN:   if (bus.DATA_VALID) cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A bin arriving outside DRAIN is discarded and latched as a sticky error.
  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (SCLR) begin
      bus.bin_re     <= '0;
      bus.bin_im     <= '0;
      bus.bin_exp    <= '0;
      bus.bin_idx    <= '0;
      bus.bin_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.bin_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.DATA_VALID) begin
        if (state == DRAIN) begin
          bus.bin_re     <= bus.XK_RE;
          bus.bin_im     <= bus.XK_IM;
          bus.bin_exp    <= bus.BLK_EXP;
          bus.bin_idx    <= cnt;
          bus.bin_valid  <= 1'b1;
          bus.frame_done <= last_bin;
        end else begin
          bus.err <= 1'b1;
        end
      end
      if (timeout_hit && !last_bin) bus.err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Directed, table-driven bench for dft_frame_sequencer at POINTS=4, TIMEOUT=16.
// Covers DFT_SEQ_TIMEOUT_EN in either build.
module tb_dft_frame_sequencer;
  import dft_pkg::*;

  localparam int N       = 18;
  localparam int POINTS  = 4;
  localparam int TIMEOUT = 16;

  logic clk  = 1'b0;
  logic sclr = 1'b1;
  always #4 clk = ~clk;

  dft_frame_sequencer_if #(.N(N), .POINTS(POINTS)) bus ();

  dft_frame_sequencer #(.N(N), .POINTS(POINTS), .TIMEOUT(TIMEOUT)) dut (
    .CLK_125MHZ_FPGA (clk),
    .SCLR            (sclr),
    .bus             (bus)
  );

  // Stimulus samples double as the expected XN_RE stream; core bins double as
  // the expected bin_* stream.
  typedef struct packed {
    logic [3:0][N-1:0] samp;
    logic [3:0][N-1:0] re;
    logic [3:0][N-1:0] im;
    logic [3:0][3:0]   ex;
    int                rffd_delay;
    int                gap_at;
  } frame_vec_t;

  frame_vec_t vecs [2];
  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [N-1:0] re, input logic [N-1:0] im,
                               input logic [3:0] ex);
    bus.DATA_VALID = dv;
    bus.XK_RE      = re;
    bus.XK_IM      = im;
    bus.BLK_EXP    = ex;
  endtask

  task automatic check_reset();
    checkOutput("rst_ready", 32'(bus.sample_ready), 32'd1);
    checkOutput("rst_fd_in", 32'(bus.FD_IN), 32'd0);
    checkOutput("rst_xn_re", 32'(bus.XN_RE), 32'd0);
    checkOutput("rst_bin_valid", 32'(bus.bin_valid), 32'd0);
    checkOutput("rst_bin_re", 32'(bus.bin_re), 32'd0);
    checkOutput("rst_bin_im", 32'(bus.bin_im), 32'd0);
    checkOutput("rst_bin_exp", 32'(bus.bin_exp), 32'd0);
    checkOutput("rst_bin_idx", 32'(bus.bin_idx), 32'd0);
    checkOutput("rst_frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
  endtask

  task automatic pulse_reset();
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check_reset();
  endtask

  task automatic fill_frame(input logic [3:0][N-1:0] s);
    for (int i = 0; i < POINTS; i++) begin
      @(negedge clk);
      checkOutput("fill_ready", 32'(bus.sample_ready), 32'd1);
      bus.sample_valid = 1'b1;
      bus.sample_in    = s[i];
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    checkOutput("wait_ready", 32'(bus.sample_ready), 32'd0);
    checkOutput("wait_fd_in", 32'(bus.FD_IN), 32'd0);
  endtask

  // Offers junk samples while RFFD is low; they must be dropped.
  task automatic wait_rffd(input int delay);
    for (int d = 0; d < delay; d++) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 18'h2AAAA;
      @(negedge clk);
      checkOutput("hold_ready", 32'(bus.sample_ready), 32'd0);
      checkOutput("hold_fd_in", 32'(bus.FD_IN), 32'd0);
    end
    bus.sample_valid = 1'b0;
    bus.RFFD         = 1'b1;
  endtask

  task automatic feed_frame(input logic [3:0][N-1:0] s);
    for (int i = 0; i < POINTS; i++) begin
      @(negedge clk);
      bus.RFFD = 1'b0;
      checkOutput($sformatf("feed_xn_%0d", i), 32'(bus.XN_RE), 32'(s[i]));
      checkOutput($sformatf("feed_fd_%0d", i), 32'(bus.FD_IN), (i == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_bin(input frame_vec_t v, input int j);
    checkOutput($sformatf("bin_valid_%0d", j), 32'(bus.bin_valid), 32'd1);
    checkOutput($sformatf("bin_idx_%0d", j), 32'(bus.bin_idx), 32'(j));
    checkOutput($sformatf("bin_re_%0d", j), 32'(bus.bin_re), 32'(v.re[j]));
    checkOutput($sformatf("bin_im_%0d", j), 32'(bus.bin_im), 32'(v.im[j]));
    checkOutput($sformatf("bin_exp_%0d", j), 32'(bus.bin_exp), 32'(v.ex[j]));
    checkOutput($sformatf("frame_done_%0d", j), 32'(bus.frame_done), (j == POINTS - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic drain_frame(input frame_vec_t v);
    @(negedge clk);
    checkOutput("drain_xn_re", 32'(bus.XN_RE), 32'd0);
    checkOutput("drain_fd_in", 32'(bus.FD_IN), 32'd0);
    checkOutput("drain_ready", 32'(bus.sample_ready), 32'd0);
    applyStimulus(1'b1, v.re[0], v.im[0], v.ex[0]);
    for (int j = 1; j < POINTS; j++) begin
      @(negedge clk);
      check_bin(v, j - 1);
      if (j == v.gap_at) begin
        applyStimulus(1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("gap_bin_valid", 32'(bus.bin_valid), 32'd0);
        checkOutput("gap_bin_re_hold", 32'(bus.bin_re), 32'(v.re[j - 1]));
      end
      applyStimulus(1'b1, v.re[j], v.im[j], v.ex[j]);
    end
    @(negedge clk);
    check_bin(v, POINTS - 1);
    checkOutput("done_ready", 32'(bus.sample_ready), 32'd1);
    applyStimulus(1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("post_bin_valid", 32'(bus.bin_valid), 32'd0);
    checkOutput("post_frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("post_bin_re_hold", 32'(bus.bin_re), 32'(v.re[POINTS - 1]));
  endtask

  task automatic run_frame(input frame_vec_t v);
    fill_frame(v.samp);
    wait_rffd(v.rffd_delay);
    feed_frame(v.samp);
    drain_frame(v);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_vec_t v;

    vecs[0].samp       = {18'd3, 18'd2, 18'd1, 18'd0};
    vecs[0].re         = {18'd40, 18'd30, 18'd20, 18'd10};
    vecs[0].im         = {18'h3FFFC, 18'h3FFFD, 18'h3FFFE, 18'h3FFFF};
    vecs[0].ex         = {4'd4, 4'd3, 4'd2, 4'd1};
    vecs[0].rffd_delay = 50;
    vecs[0].gap_at     = 0;
    vecs[1].samp       = {18'd7, 18'h20000, 18'h1FFFF, 18'h3FFFB};
    vecs[1].re         = {18'h2AAAA, 18'h15555, 18'h3FF00, 18'h00100};
    vecs[1].im         = {18'd8, 18'd7, 18'd6, 18'd5};
    vecs[1].ex         = {4'd6, 4'd9, 4'd0, 4'd15};
    vecs[1].rffd_delay = 3;
    vecs[1].gap_at     = 2;

    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.RFFD         = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    sclr = 1'b0;
    check_reset();

    for (int k = 0; k < 2; k++) run_frame(vecs[k]);

    // Reset after point 1 of FEED; the following frame must use fresh samples.
    v.samp = {18'd8, 18'd7, 18'd6, 18'd5};
    fill_frame(v.samp);
    wait_rffd(0);
    @(negedge clk);
    bus.RFFD = 1'b0;
    checkOutput("midfeed_xn_0", 32'(bus.XN_RE), 32'd5);
    @(negedge clk);
    checkOutput("midfeed_xn_1", 32'(bus.XN_RE), 32'd6);
    pulse_reset();
    run_frame(vecs[0]);

    // Reset with a partial frame in the buffer; write pointer must restart.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample_in    = 18'(99 - i);
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    pulse_reset();
    run_frame(vecs[1]);

    // Stray DATA_VALID during FILL sets a sticky error and produces no bin.
    @(negedge clk);
    applyStimulus(1'b1, 18'h00123, 18'h00456, 4'd7);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("stray_err", 32'(bus.err), 32'd1);
    checkOutput("stray_bin_valid", 32'(bus.bin_valid), 32'd0);
    checkOutput("stray_bin_re", 32'(bus.bin_re), 32'(vecs[1].re[3]));
    checkOutput("stray_ready", 32'(bus.sample_ready), 32'd1);
    run_frame(vecs[0]);
    checkOutput("err_sticky", 32'(bus.err), 32'd1);
    pulse_reset();

    // Only two bins returned from the core.
    fill_frame(vecs[0].samp);
    wait_rffd(0);
    feed_frame(vecs[0].samp);
    @(negedge clk);
    applyStimulus(1'b1, vecs[0].re[0], vecs[0].im[0], vecs[0].ex[0]);
    @(negedge clk);
    applyStimulus(1'b1, vecs[0].re[1], vecs[0].im[1], vecs[0].ex[1]);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("short_bin_idx", 32'(bus.bin_idx), 32'd1);
`ifdef DFT_SEQ_TIMEOUT_EN
    for (int c = 4; c <= TIMEOUT; c++) begin
      @(negedge clk);
      checkOutput("to_frame_done", 32'(bus.frame_done), 32'd0);
    end
    checkOutput("to_err_before", 32'(bus.err), 32'd0);
    checkOutput("to_ready_before", 32'(bus.sample_ready), 32'd0);
    @(negedge clk);
    checkOutput("to_err_after", 32'(bus.err), 32'd1);
    checkOutput("to_ready_after", 32'(bus.sample_ready), 32'd1);
    checkOutput("to_frame_done_after", 32'(bus.frame_done), 32'd0);
`else
    repeat (2 * TIMEOUT) @(negedge clk);
    checkOutput("nt_ready_waiting", 32'(bus.sample_ready), 32'd0);
    checkOutput("nt_err_waiting", 32'(bus.err), 32'd0);
    applyStimulus(1'b1, vecs[0].re[2], vecs[0].im[2], vecs[0].ex[2]);
    @(negedge clk);
    applyStimulus(1'b1, vecs[0].re[3], vecs[0].im[3], vecs[0].ex[3]);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, '0);
    check_bin(vecs[0], 3);
    checkOutput("nt_ready_done", 32'(bus.sample_ready), 32'd1);
    checkOutput("nt_err_done", 32'(bus.err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
